hci_copy_fault_collector: RTL

// Downstream consumer of the fault_detected_o flags from a set of hci_copy_sink

---
 rtl/hci_copy_fault_collector_pkg.sv | 10 +
 rtl/hci_copy_fault_collector.sv | 117 +++++++++++
 2 files changed

// File: rtl/hci_copy_fault_collector_pkg.sv
// Shared types for the HCI copy fault collector and future fault-reporting register files.
package hci_copy_fault_collector_pkg;

    typedef enum logic [1:0] {
        FLT_OK      = 2'd0,
        FLT_ALERT   = 2'd1,
        FLT_LATCHED = 2'd2
    } hci_copy_fault_state_e;

endpackage

// File: rtl/hci_copy_fault_collector.sv
// Collects hci_copy_sink fault flags: registers/gates them, keeps sticky status, a saturating
// fault-cycle counter and first-fault index, and raises a level interrupt held until acknowledged.
module hci_copy_fault_collector
    import hci_copy_fault_collector_pkg::*;
#(
    parameter int unsigned NumSinks = 4,
    parameter int unsigned CntWidth = 16,
    parameter int unsigned IdxWidth = (NumSinks > 1) ? $clog2(NumSinks) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                clear_i,
    input  logic                ack_i,
    input  logic [CntWidth-1:0] threshold_i,
    input  logic [NumSinks-1:0] fault_i,
    output logic                irq_o,
    output logic [NumSinks-1:0] fault_sticky_o,
    output logic [IdxWidth-1:0] first_idx_o,
    output logic                first_valid_o,
    output logic [CntWidth-1:0] fault_count_o,
    output logic                persistent_o
);

    // Lowest set bit wins so the reported index is deterministic when several sinks fault together.
    function automatic logic [IdxWidth-1:0] lowest_set(input logic [NumSinks-1:0] v);
        lowest_set = '0;
        for (int i = NumSinks - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IdxWidth'(i);
        end
    endfunction

    logic [NumSinks-1:0]   fault_q;
    logic [NumSinks-1:0]   sticky_q, sticky_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [IdxWidth-1:0]   first_idx_q, first_idx_d;
    logic                  first_valid_q, first_valid_d;
    logic                  irq_q;
    hci_copy_fault_state_e state_q;
    logic                  any;

    assign any = |fault_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_q <= '0;
        end else if (clear_i) begin
            fault_q <= '0;
        end else begin
            fault_q <= enable_i ? fault_i : '0;
        end
    end

    always_comb begin
        sticky_d      = sticky_q | fault_q;
        count_d       = count_q;
        first_idx_d   = first_idx_q;
        first_valid_d = first_valid_q;
        if (any && (count_q != {CntWidth{1'b1}})) begin
            count_d = count_q + CntWidth'(1);
        end
        if (any && !first_valid_q) begin
            first_idx_d   = lowest_set(fault_q);
            first_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= FLT_OK;
            irq_q         <= 1'b0;
            sticky_q      <= '0;
            count_q       <= '0;
            first_idx_q   <= '0;
            first_valid_q <= 1'b0;
        end else if (clear_i) begin
            state_q       <= FLT_OK;
            irq_q         <= 1'b0;
            sticky_q      <= '0;
            count_q       <= '0;
            first_idx_q   <= '0;
            first_valid_q <= 1'b0;
        end else begin
            sticky_q      <= sticky_d;
            count_q       <= count_d;
            first_idx_q   <= first_idx_d;
            first_valid_q <= first_valid_d;
            // Ack takes priority over a fault arriving in the same cycle while alerting.
            case (state_q)
                FLT_OK, FLT_LATCHED: begin
                    if (any) begin
                        state_q <= FLT_ALERT;
                        irq_q   <= 1'b1;
                    end
                end
                FLT_ALERT: begin
                    if (ack_i) begin
                        state_q <= FLT_LATCHED;
                        irq_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FLT_OK;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o          = irq_q;
    assign fault_sticky_o = sticky_q;
    assign first_idx_o    = first_idx_q;
    assign first_valid_o  = first_valid_q;
    assign fault_count_o  = count_q;
    assign persistent_o   = (threshold_i != '0) && (count_q >= threshold_i);

endmodule
